// File: rtl/hdmi_mode_sequencer.sv
// -----------------------------------------------------------------------------
// hdmi_mode_sequencer
//
// Purpose
//   Sequences NTSC/PAL timing switches for the dual-timing HDMI output stage
//   (VIC 2 / VIC 17 pair). A pal_mode request coming from the VDP register
//   file is first filtered for stability. Audio packets are then muted and the
//   block waits for a frame boundary. It then holds the HDMI encoders in reset
//   while the applied timing flips. Audio comes back once the new timing has
//   reached frame start. Everything lives in the clk_pixel domain.
//
// Parameters
//   STABLE_CYCLES  consecutive cycles pal_mode_req must differ from pal_mode
//                  before a switch starts
//   MUTE_CYCLES    cycles include_audio is held low before the frame wait
//   RESET_CYCLES   cycles hdmi_reset is held high during a switch
//   FRAME_TIMEOUT  max cycles spent waiting for cx==0 && cy==0 (must exceed
//                  one PAL frame, 540000 pixel clocks)
//
// Ports
//   clk_pixel      in   1   pixel clock, sole clock
//   reset          in   1   synchronous, active-high
//   pal_mode_req   in   1   requested timing from VDP (1 = PAL)
//   audio_en_req   in   1   requested audio enable
//   cx             in   11  horizontal counter from HDMI stage
//   cy             in   10  vertical counter from HDMI stage
//   pal_mode       out  1   applied timing select to HDMI stage
//   hdmi_reset     out  1   reset to HDMI encoders
//   include_audio  out  1   audio packet enable to HDMI stage
//   busy           out  1   high in every state except IDLE
//   mode_switched  out  1   one-cycle pulse when a switch completes
//
// Observability
//   The FSM state is held in the enum-typed signal `state` (type state_t).
//   Checkers can bind to it by name. All outputs are registered and derived
//   from the state being entered, so each output matches `state` on the same
//   cycle.
// -----------------------------------------------------------------------------
module hdmi_mode_sequencer #(
    parameter int STABLE_CYCLES = 1024,
    parameter int MUTE_CYCLES   = 2048,
    parameter int RESET_CYCLES  = 16,
    parameter int FRAME_TIMEOUT = 1000000
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        pal_mode_req,
    input  logic        audio_en_req,
    input  logic [10:0] cx,
    input  logic [9:0]  cy,
    output logic        pal_mode,
    output logic        hdmi_reset,
    output logic        include_audio,
    output logic        busy,
    output logic        mode_switched
);

    // -------------------------------------------------------------------------
    // Counter sizing: one shared phase counter, wide enough for the largest
    // parameter. It saturates so that a long IDLE stay cannot wrap it.
    // -------------------------------------------------------------------------
    localparam int MAX_SM  = (STABLE_CYCLES > MUTE_CYCLES) ? STABLE_CYCLES : MUTE_CYCLES;
    localparam int MAX_RF  = (RESET_CYCLES > FRAME_TIMEOUT) ? RESET_CYCLES : FRAME_TIMEOUT;
    localparam int MAX_ALL = (MAX_SM > MAX_RF) ? MAX_SM : MAX_RF;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_SAT       = '1;
    localparam logic [CNT_W-1:0]  MUTE_LAST     = CNT_W'(MUTE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RESET_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST  = CNT_W'(FRAME_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SETTLE_MIN    = CNT_W'(2);
    localparam logic [STAB_W-1:0] STABLE_LAST   = STAB_W'(STABLE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MUTE       = 3'd1,
        S_WAIT_FRAME = 3'd2,
        S_RST        = 3'd3,
        S_SETTLE     = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [CNT_W-1:0]    cnt;
    logic [STAB_W-1:0]   stab_cnt;
    logic [STAB_W-1:0]   stab_next;
    logic                target;
    logic                target_next;
    logic                pal_next;
    logic                powerup;
    logic                switch_done;

    // A mismatch means the VDP currently asks for the other timing.
    logic                mismatch;
    logic                frame_start;

    assign mismatch    = (pal_mode_req != pal_mode);
    assign frame_start = (cx == 11'd0) && (cy == 10'd0);

    // -------------------------------------------------------------------------
    // Next-state and next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        stab_next   = '0;
        target_next = target;
        pal_next    = pal_mode;
        switch_done = 1'b0;

        case (state)
            S_IDLE: begin
                // The filter only runs in IDLE. Leaving IDLE clears it, so a
                // request that flips again later is filtered from scratch.
                if (mismatch) begin
                    if (stab_cnt == STABLE_LAST) begin
                        state_next  = S_MUTE;
                        target_next = pal_mode_req;
                    end else begin
                        stab_next = stab_cnt + STAB_W'(1);
                    end
                end
            end

            S_MUTE: begin
                // A withdrawn request wins over the mute timer expiring.
                if (!mismatch) begin
                    state_next = S_IDLE;
                end else if (cnt == MUTE_LAST) begin
                    state_next = S_WAIT_FRAME;
                end
            end

            S_WAIT_FRAME: begin
                // A withdrawn request also wins over the frame/timeout exit.
                // The timing flips on entry to S_RST.
                if (!mismatch) begin
                    state_next = S_IDLE;
                end else if (frame_start || (cnt == TIMEOUT_LAST)) begin
                    state_next = S_RST;
                    pal_next   = target;
                end
            end

            S_RST: begin
                // Request changes are deliberately ignored here. They are
                // picked up again from IDLE once the switch has finished.
                if (cnt == RESET_LAST) begin
                    state_next = S_SETTLE;
                end
            end

            S_SETTLE: begin
                // cnt >= 2 skips any stale (0,0) position still reported while
                // the encoders come out of reset. The new timing has to reach
                // a real frame start.
                if (((cnt >= SETTLE_MIN) && frame_start) || (cnt == TIMEOUT_LAST)) begin
                    state_next  = S_IDLE;
                    switch_done = !powerup;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            // Power-up and mid-switch reset both take the RST -> SETTLE -> IDLE
            // path. The request is applied directly, with no stability filter.
            state         <= S_RST;
            cnt           <= '0;
            stab_cnt      <= '0;
            target        <= pal_mode_req;
            pal_mode      <= pal_mode_req;
            powerup       <= 1'b1;
            hdmi_reset    <= 1'b1;
            include_audio <= 1'b0;
            busy          <= 1'b1;
            mode_switched <= 1'b0;
        end else begin
            state    <= state_next;
            stab_cnt <= stab_next;
            target   <= target_next;
            pal_mode <= pal_next;

            // The counter restarts from zero on every state entry.
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + CNT_W'(1);
            end

            if ((state == S_SETTLE) && (state_next == S_IDLE)) begin
                powerup <= 1'b0;
            end

            hdmi_reset    <= (state_next == S_RST);
            busy          <= (state_next != S_IDLE);
            mode_switched <= switch_done;

            // Audio follows the request (one cycle late) only while staying in
            // IDLE. It drops on the same edge that leaves IDLE. After a switch
            // it returns one cycle after IDLE is re-entered, so it can never
            // rise while hdmi_reset is high.
            include_audio <= (state == S_IDLE) && (state_next == S_IDLE) && audio_en_req;
        end
    end

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hdmi_mode_sequencer
//
// Self-checking bench for hdmi_mode_sequencer with small parameters
// (STABLE=4, MUTE=8, RESET=3, TIMEOUT=100) and a 10x5 cx/cy frame.
// Every clock step is compared against a behavioural reference model.
// On top of that, a vector table and directed sequences check the exact
// cycle counts.
// -----------------------------------------------------------------------------
module tb_hdmi_mode_sequencer;

    localparam int STABLE = 4;
    localparam int MUTE   = 8;
    localparam int RSTC   = 3;
    localparam int TO     = 100;
    localparam int FW     = 10;
    localparam int FH     = 5;

    // ---------------------------------------------------------------- clock
    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic        pal_mode_req = 1'b0;
    logic        audio_en_req = 1'b0;
    logic [10:0] cx = '0;
    logic [9:0]  cy = '0;
    logic        pal_mode;
    logic        hdmi_reset;
    logic        include_audio;
    logic        busy;
    logic        mode_switched;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_mode_sequencer #(
        .STABLE_CYCLES (STABLE),
        .MUTE_CYCLES   (MUTE),
        .RESET_CYCLES  (RSTC),
        .FRAME_TIMEOUT (TO)
    ) dut (
        .clk_pixel     (clk_pixel),
        .reset         (reset),
        .pal_mode_req  (pal_mode_req),
        .audio_en_req  (audio_en_req),
        .cx            (cx),
        .cy            (cy),
        .pal_mode      (pal_mode),
        .hdmi_reset    (hdmi_reset),
        .include_audio (include_audio),
        .busy          (busy),
        .mode_switched (mode_switched)
    );

    int total = 0;
    int bad   = 0;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ reference
    // The phases are the names of the switch procedure. Time is tracked as
    // absolute edge stamps rather than counters.
    localparam int PH_IDLE   = 0;
    localparam int PH_MUTE   = 1;
    localparam int PH_WAIT   = 2;
    localparam int PH_RST    = 3;
    localparam int PH_SETTLE = 4;

    int m_phase    = PH_RST;
    int m_ent      = 0;
    int cyc        = 0;
    int m_mm_start = 0;
    bit m_mm_valid = 0;
    bit m_pal      = 0;
    bit m_target   = 0;
    bit m_boot     = 1;
    bit e_pal, e_hrst, e_aud, e_busy, e_sw;

    task automatic model_step(input bit rst, input bit req, input bit aud, input bit fs);
        int nxt;
        int age;
        bit sw;
        bit was_idle;
        nxt      = m_phase;
        age      = cyc - m_ent;
        sw       = 1'b0;
        was_idle = (m_phase == PH_IDLE);
        if (rst) begin
            m_phase    = PH_RST;
            m_ent      = cyc + 1;
            m_pal      = req;
            m_boot     = 1'b1;
            m_mm_valid = 1'b0;
            e_pal = req; e_hrst = 1'b1; e_aud = 1'b0; e_busy = 1'b1; e_sw = 1'b0;
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    if (req != m_pal) begin
                        if (!m_mm_valid) begin
                            m_mm_valid = 1'b1;
                            m_mm_start = cyc;
                        end
                        // Fires on the STABLE-th consecutive mismatching edge.
                        if (cyc - m_mm_start + 1 == STABLE) begin
                            nxt      = PH_MUTE;
                            m_target = req;
                        end
                    end else begin
                        m_mm_valid = 1'b0;
                    end
                end
                PH_MUTE: begin
                    if (req == m_pal) nxt = PH_IDLE;
                    else if (age == MUTE - 1) nxt = PH_WAIT;
                end
                PH_WAIT: begin
                    if (req == m_pal) nxt = PH_IDLE;
                    else if (fs || age == TO - 1) begin
                        nxt   = PH_RST;
                        m_pal = m_target;
                    end
                end
                PH_RST: begin
                    if (age == RSTC - 1) nxt = PH_SETTLE;
                end
                default: begin
                    if ((age >= 2 && fs) || age == TO - 1) begin
                        nxt    = PH_IDLE;
                        sw     = !m_boot;
                        m_boot = 1'b0;
                    end
                end
            endcase
            if (nxt != m_phase) begin
                m_ent      = cyc + 1;
                m_mm_valid = 1'b0;
            end
            e_aud   = (was_idle && nxt == PH_IDLE) ? aud : 1'b0;
            e_hrst  = (nxt == PH_RST);
            e_busy  = (nxt != PH_IDLE);
            e_sw    = sw;
            e_pal   = m_pal;
            m_phase = nxt;
        end
        cyc++;
    endtask

    // ------------------------------------------------------------ checks
    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %b, required %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ drivers
    int fx = 0;
    int fy = 0;
    bit frozen  = 0;
    bit last_fs = 0;

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, compare all outputs 1 time unit later.
    task automatic tick(input bit rst, input bit req, input bit aud, input int x, input int y);
        @(negedge clk_pixel);
        reset        = rst;
        pal_mode_req = req;
        audio_en_req = aud;
        cx           = x[10:0];
        cy           = y[9:0];
        @(posedge clk_pixel);
        model_step(rst, req, aud, (x == 0) && (y == 0));
        #1;
        check_bit("pal_mode",      pal_mode,      e_pal);
        check_bit("hdmi_reset",    hdmi_reset,    e_hrst);
        check_bit("include_audio", include_audio, e_aud);
        check_bit("busy",          busy,          e_busy);
        check_bit("mode_switched", mode_switched, e_sw);
    endtask

    // Same, with cx/cy taken from the free-running 10x5 frame.
    task automatic tickf(input bit rst, input bit req, input bit aud);
        int x;
        int y;
        x = fx;
        y = fy;
        last_fs = (x == 0) && (y == 0);
        tick(rst, req, aud, x, y);
        if (!frozen) begin
            fx++;
            if (fx == FW) begin
                fx = 0;
                fy++;
                if (fy == FH) fy = 0;
            end
        end
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        bit rst;
        bit req;
        bit aud;
        int x;
        int y;
        bit pal;
        bit hrst;
        bit inc;
        bit bsy;
        bit sw;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    initial begin
        int fall_k, first_fs, rise_k, hrst_n, sw_n, done_k, k;
        bit pal_bad, sw_aud, hrst_seen, sw_seen;

        // Power-up with req=1, then a 3-cycle glitch, then audio lag.
        //          rst req aud  x  y   pal hrst inc bsy sw
        tbl[0]  = '{1, 1, 1, 3, 1,  1, 1, 0, 1, 0};
        tbl[1]  = '{1, 1, 1, 3, 1,  1, 1, 0, 1, 0};
        tbl[2]  = '{0, 1, 1, 3, 1,  1, 1, 0, 1, 0};
        tbl[3]  = '{0, 1, 1, 3, 1,  1, 1, 0, 1, 0};
        tbl[4]  = '{0, 1, 1, 3, 1,  1, 0, 0, 1, 0};
        tbl[5]  = '{0, 1, 1, 0, 0,  1, 0, 0, 1, 0};
        tbl[6]  = '{0, 1, 1, 0, 0,  1, 0, 0, 1, 0};
        tbl[7]  = '{0, 1, 1, 0, 0,  1, 0, 0, 0, 0};
        tbl[8]  = '{0, 1, 1, 1, 0,  1, 0, 1, 0, 0};
        tbl[9]  = '{0, 0, 1, 2, 0,  1, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 1, 3, 0,  1, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 1, 4, 0,  1, 0, 1, 0, 0};
        tbl[12] = '{0, 1, 1, 5, 0,  1, 0, 1, 0, 0};
        tbl[13] = '{0, 1, 0, 6, 0,  1, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 1, 7, 0,  1, 0, 1, 0, 0};
        tbl[15] = '{0, 1, 1, 0, 0,  1, 0, 1, 0, 0};

        for (int i = 0; i < NV; i++) begin
            tick(tbl[i].rst, tbl[i].req, tbl[i].aud, tbl[i].x, tbl[i].y);
            check_bit($sformatf("vec%0d.pal_mode", i),      pal_mode,      tbl[i].pal);
            check_bit($sformatf("vec%0d.hdmi_reset", i),    hdmi_reset,    tbl[i].hrst);
            check_bit($sformatf("vec%0d.include_audio", i), include_audio, tbl[i].inc);
            check_bit($sformatf("vec%0d.busy", i),          busy,          tbl[i].bsy);
            check_bit($sformatf("vec%0d.mode_switched", i), mode_switched, tbl[i].sw);
        end

        // ---- bring up with pal_mode=0
        tickf(1, 0, 1);
        tickf(1, 0, 1);
        done_k = -1;
        for (int i = 1; i <= 300; i++) begin
            tickf(0, 0, 1);
            if (!busy) begin done_k = i; break; end
        end
        check_bit("bringup_idle", (done_k > 0), 1'b1);
        check_bit("bringup_pal", pal_mode, 1'b0);
        tickf(0, 0, 1);

        // ---- switch 0 -> 1
        fall_k = -1;
        for (int i = 1; i <= 20; i++) begin
            tickf(0, 1, 1);
            if (!include_audio) begin fall_k = i; break; end
        end
        check_int("sw01_mute_latency", fall_k, 4);
        first_fs = -1; rise_k = -1; hrst_n = 0; sw_n = 0; done_k = -1;
        pal_bad = 0; sw_aud = 1;
        for (int i = 1; i <= 300; i++) begin
            tickf(0, 1, 1);
            if (i >= MUTE + 1 && last_fs && first_fs < 0) first_fs = i;
            if (hdmi_reset && rise_k < 0) rise_k = i;
            if (hdmi_reset) hrst_n++;
            if (hdmi_reset && !pal_mode) pal_bad = 1;
            if (mode_switched) begin sw_n++; sw_aud = include_audio; end
            if (!busy) begin done_k = i; break; end
        end
        check_bit("sw01_done", (done_k > 0), 1'b1);
        check_int("sw01_reset_at_frame", rise_k, first_fs);
        check_int("sw01_reset_len", hrst_n, RSTC);
        check_bit("sw01_pal_in_reset", pal_bad, 1'b0);
        check_int("sw01_pulses", sw_n, 1);
        check_bit("sw01_audio_at_pulse", sw_aud, 1'b0);
        tickf(0, 1, 1);
        check_bit("sw01_audio_restored", include_audio, 1'b1);
        check_bit("sw01_pulse_one_cycle", mode_switched, 1'b0);

        // ---- withdraw in WAIT_FRAME (frame frozen so no boundary occurs)
        frozen = 1; fx = 5; fy = 2;
        hrst_seen = 0;
        for (int i = 1; i <= STABLE + MUTE + 5; i++) begin
            tickf(0, 0, 1);
            if (hdmi_reset) hrst_seen = 1;
        end
        check_bit("wd_in_wait", busy, 1'b1);
        tickf(0, 1, 1);
        check_bit("wd_idle_next", busy, 1'b0);
        check_bit("wd_no_reset", hrst_seen | hdmi_reset, 1'b0);
        check_bit("wd_pal_kept", pal_mode, 1'b1);

        // ---- timeout in WAIT_FRAME and SETTLE
        for (int i = 1; i <= STABLE + MUTE; i++) tickf(0, 0, 1);
        check_bit("to_wait_entered", busy & !hdmi_reset, 1'b1);
        k = -1;
        for (int i = 1; i <= 150; i++) begin
            tickf(0, 0, 1);
            if (hdmi_reset) begin k = i; break; end
        end
        check_int("to_wait_len", k, TO);
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            tickf(0, 0, 1);
            if (!hdmi_reset) begin k = i; break; end
        end
        check_int("to_rst_len", k, RSTC);
        k = -1;
        for (int i = 1; i <= 150; i++) begin
            tickf(0, 0, 1);
            if (!busy) begin k = i; break; end
        end
        check_int("to_settle_len", k, TO);
        check_bit("to_switched", mode_switched, 1'b1);
        check_bit("to_pal", pal_mode, 1'b0);

        // ---- reset in the middle of the hdmi_reset pulse
        frozen = 0;
        k = -1;
        for (int i = 1; i <= 300; i++) begin
            tickf(0, 1, 1);
            if (hdmi_reset) begin k = i; break; end
        end
        check_bit("mr_reached_rst", (k > 0), 1'b1);
        tickf(0, 1, 1);
        tickf(1, 0, 1);
        tickf(1, 0, 1);
        check_bit("mr_pal_from_req", pal_mode, 1'b0);
        check_bit("mr_reset_high", hdmi_reset, 1'b1);
        k = -1; sw_seen = 0; done_k = -1;
        for (int i = 1; i <= 300; i++) begin
            tickf(0, 0, 1);
            if (!hdmi_reset && k < 0) k = i;
            if (mode_switched) sw_seen = 1;
            if (!busy) begin done_k = i; break; end
        end
        check_int("mr_reset_len", k, RSTC);
        check_bit("mr_done", (done_k > 0), 1'b1);
        check_bit("mr_no_pulse", sw_seen, 1'b0);

        // ---- randomized run against the model
        begin
            bit r_req, r_aud, r_rst;
            r_req = pal_mode_req;
            r_aud = 1'b1;
            for (int i = 0; i < 20000; i++) begin
                r_rst = ($urandom_range(0, 3999) == 0);
                if ($urandom_range(0, 59) == 0) r_req = ~r_req;
                if ($urandom_range(0, 9) == 0)  r_aud = ~r_aud;
                if ($urandom_range(0, 399) == 0) frozen = ~frozen;
                tickf(r_rst, r_req, r_aud);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
